jolt_finder_stream: RTL and testbench
=====================================

// Module: jolt_finder_stream
// PURPOSE
//  Streaming, parametrised max-joltage finder. Accepts one bank of BCD digits (one digit per beat),
//  then selects NUM_PICK digits in original order that form the largest possible NUM_PICK-digit number.
//  Emits each per-bank result through a valid/ready handshake and keeps a running BCD sum across banks.
//  Sits between the digit parser and the result/UART reporting path.
// PARAMETERS
//  MAX_LEN     128  bank buffer depth in digits (maximum bank length)
//  NUM_PICK    2    digits selected per bank (12 for long mode); 1 <= NUM_PICK <= MAX_LEN
//  ACC_DIGITS  16   BCD digits in the running sum
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               synchronous reset, active-high
//  in_valid  in   1               in_digit/in_last valid
//  in_ready  out  1               block accepts a digit (high only in LOAD)
//  in_digit  in   4               BCD digit
//  in_last   in   1               final digit of the bank
//  out_valid out  1               result valid, held until accepted
//  out_ready in   1               consumer accepts the result
//  out_bcd   out  4*NUM_PICK      selected digits, first pick in the MS nibble
//  out_pos   out  $clog2(MAX_LEN) index of the first picked digit in the bank
//  out_err   out  1               bank invalid: too short, overflowed, or contains a non-BCD digit
//  sum_clr   in   1               clear the running sum
//  sum_bcd   out  4*ACC_DIGITS    running BCD sum of accepted error-free results
// BEHAVIOUR
//  Reset: state=LOAD, count=0, in_ready=1, out_valid=0, out_bcd=0, out_pos=0, out_err=0, sum_bcd=0.
//  FSM LOAD -> SCAN -> OUT -> LOAD.
//  LOAD: on in_valid&&in_ready, write buf[count] and increment count.
//   - A digit beyond MAX_LEN is dropped and sets the ovf flag.
//   - A digit >9 sets the bad flag.
//   - The beat with in_last goes to SCAN on the next cycle; in_ready=0 from that cycle.
//  SCAN (greedy, pick k=0..NUM_PICK-1):
//   - Window is [s, n-NUM_PICK+k]; s=0 for k=0, and s=argmax(previous pick)+1 thereafter.
//   - One buffer entry compared per cycle; strict '>' keeps the first occurrence of the maximum.
//   - The window ends early when a 9 is found.
//   - At window end, shift the max into out_bcd, record out_pos when k==0, and start the next window.
//   - If n<NUM_PICK, ovf, or bad: skip the scan, out_bcd=0, out_pos=0, out_err=1.
//  OUT: out_valid=1; out_bcd/out_pos/out_err stay stable until out_valid&&out_ready.
//   - On that handshake: return to LOAD with count/flags cleared; out_valid drops the next cycle.
//  Latency: worst case (n-NUM_PICK+1)*NUM_PICK + 1 cycles from the in_last beat to out_valid.
//   - Example: NUM_PICK=2, n=5, no 9s -> 9 cycles.
//  Sum: on the output handshake with out_err=0, sum_bcd <= sum_bcd + zero-extended out_bcd.
//   - Decimal addition, wraps modulo 10^ACC_DIGITS.
//   - sum_clr has priority: if coincident with a handshake, sum becomes 0 and that result is not added.
//   - sum_clr is honoured in any state.
//  rst in any state aborts the bank and restores reset values; a partially loaded bank is discarded.
//  Single-digit bank with NUM_PICK=1 is legal: window [0,0], result = that digit.
// STRUCTURE
//  Shared package jolt_pkg:
//   - state encoding localparams (LOAD, SCAN, OUT)
//   - BCD_W=4
//   - digit-valid function (d<=9)
//  Sub-module bcd_adder #(DIGITS): combinational ripple BCD adder with per-digit +6 correction,
//   used for the running sum.
//  Buffer is a register array (distributed RAM acceptable; read address registered in SCAN).
// TESTING
//  1. NUM_PICK=2, bank 1,2,9,8,4 -> out_bcd=8'h98, out_pos=2, out_err=0.
//  2. NUM_PICK=2, banks 987654321111111, 811111111111119, 234234234234278, 818181911112111
//     -> results 98, 89, 78, 92; sum_bcd=357.
//  3. NUM_PICK=12, same four banks -> 987654321111, 811111111119, 434234234278, 888911112111;
//     sum_bcd=3121910778619.
//  4. Handshake: hold out_ready=0 for 5 cycles -> out_* stable and in_ready=0 throughout;
//     in_valid asserted meanwhile is not accepted; next bank loads after acceptance.
//  5. Errors:
//   - NUM_PICK=12, 5-digit bank -> out_err=1, out_bcd=0, sum unchanged.
//   - Digit 4'hA -> out_err=1.
//   - MAX_LEN+3 digits -> out_err=1.
//  6. Control:
//   - rst mid-SCAN -> next cycle all outputs at reset values and in_ready=1.
//   - sum_clr coincident with a handshake -> sum_bcd=0.

Source files
------------

// File: rtl/jolt_pkg.sv
// Shared types and helpers for the streaming max-joltage finder.
// State encoding, BCD width and digit validity check.
package jolt_pkg;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    OUT
  } state_t;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/jolt_finder_stream_if.sv
// Digit input stream and per-bank result stream of the joltage finder.
// master drives digits and out_ready; slave is the finder itself.
interface jolt_finder_stream_if #(
  parameter int MAX_LEN  = 128,
  parameter int NUM_PICK = 2
) ();
  localparam int POS_W = $clog2(MAX_LEN);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_digit;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*NUM_PICK-1:0] out_bcd;
  logic [POS_W-1:0]      out_pos;
  logic                  out_err;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_pos, out_err
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_pos, out_err
  );
endinterface

// File: rtl/jolt_finder_stream_bcd_adder.sv
// Combinational ripple BCD adder; sum wraps modulo 10^DIGITS.
// Each digit adds with carry and corrects by +6 above nine.
module bcd_adder
  import jolt_pkg::*;
#(
  parameter int DIGITS = 16
) (
  input  logic [BCD_W*DIGITS-1:0] i_a,
  input  logic [BCD_W*DIGITS-1:0] i_b,
  output logic [BCD_W*DIGITS-1:0] o_sum
);
  always_comb begin
    logic       c;
    logic [4:0] s;
    c     = 1'b0;
    s     = '0;
    o_sum = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, i_a[i*BCD_W +: BCD_W]}
        + {1'b0, i_b[i*BCD_W +: BCD_W]}
        + {4'b0, c};
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      o_sum[i*BCD_W +: BCD_W] = s[3:0];
    end
  end
endmodule

// File: rtl/jolt_finder_stream.sv
// Streaming max-joltage finder: buffers a bank, greedily picks NUM_PICK
// digits forming the largest number, and keeps a running BCD sum.
module jolt_finder_stream
  import jolt_pkg::*;
#(
  parameter int MAX_LEN    = 128,
  parameter int NUM_PICK   = 2,
  parameter int ACC_DIGITS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  jolt_finder_stream_if.slave         bus,
  input  logic                        sum_clr,
  output logic [BCD_W*ACC_DIGITS-1:0] sum_bcd
);
  localparam int POS_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int OUT_W = BCD_W * NUM_PICK;
  localparam int ACC_W = BCD_W * ACC_DIGITS;

  state_t           r_state, w_next;
  logic [BCD_W-1:0] r_buf [MAX_LEN];
  logic [CNT_W-1:0] r_count, r_idx, r_k, r_arg;
  logic [BCD_W-1:0] r_max;
  logic             r_first, r_ovf, r_bad;
  logic [OUT_W-1:0] r_bcd;
  logic [POS_W-1:0] r_pos;
  logic             r_err;
  logic [ACC_W-1:0] r_sum, w_sum_nx, w_addend;

  logic             w_in_hs, w_out_hs, w_room;
  logic [BCD_W-1:0] w_rd, w_max;
  logic [CNT_W-1:0] w_arg, w_lim;
  logic             w_take, w_wend, w_skip, w_done;
  logic [OUT_W-1:0] w_shift;

  assign w_in_hs  = (r_state == LOAD) && bus.in_valid;
  assign w_out_hs = (r_state == OUT) && bus.out_ready;
  assign w_room   = r_count < CNT_W'(MAX_LEN);

  assign w_rd   = r_buf[r_idx[POS_W-1:0]];
  assign w_take = r_first || (w_rd > r_max);
  assign w_max  = w_take ? w_rd : r_max;
  assign w_arg  = w_take ? r_idx : r_arg;
  assign w_lim  = r_count - CNT_W'(NUM_PICK) + r_k;
  // a 9 cannot be beaten, so the window may stop there
  assign w_wend = (r_idx == w_lim) || (w_max == 4'd9);
  assign w_skip = r_ovf || r_bad || (r_count < CNT_W'(NUM_PICK));
  assign w_done = w_skip || (w_wend && (r_k == CNT_W'(NUM_PICK - 1)));

  if (NUM_PICK == 1) begin : g_one
    assign w_shift = w_max;
  end else begin : g_many
    assign w_shift = {r_bcd[OUT_W-BCD_W-1:0], w_max};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) w_next = SCAN;
      end
      SCAN: if (w_done) w_next = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_in_hs && w_room) r_buf[r_count[POS_W-1:0]] <= bus.in_digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_arg   <= '0;
      r_max   <= '0;
      r_first <= 1'b1;
      r_ovf   <= 1'b0;
      r_bad   <= 1'b0;
      r_bcd   <= '0;
      r_pos   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD: if (w_in_hs) begin
          if (w_room) r_count <= r_count + CNT_W'(1);
          else        r_ovf   <= 1'b1;
          if (!bcd_ok(bus.in_digit)) r_bad <= 1'b1;
          if (bus.in_last) begin
            r_idx   <= '0;
            r_k     <= '0;
            r_first <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        SCAN: if (w_skip) begin
          r_bcd <= '0;
          r_pos <= '0;
          r_err <= 1'b1;
        end else begin
          r_max <= w_max;
          r_arg <= w_arg;
          if (w_wend) begin
            r_bcd   <= w_shift;
            if (r_k == '0) r_pos <= w_arg[POS_W-1:0];
            r_k     <= r_k + CNT_W'(1);
            r_idx   <= w_arg + CNT_W'(1);
            r_first <= 1'b1;
          end else begin
            r_idx   <= r_idx + CNT_W'(1);
            r_first <= 1'b0;
          end
        end
        OUT: if (bus.out_ready) begin
          r_count <= '0;
          r_ovf   <= 1'b0;
          r_bad   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_addend = ACC_W'(r_bcd);

  bcd_adder #(.DIGITS(ACC_DIGITS)) u_add (
    .i_a   (r_sum),
    .i_b   (w_addend),
    .o_sum (w_sum_nx)
  );

  always_ff @(posedge clk) begin
    if (rst || sum_clr)           r_sum <= '0;
    else if (w_out_hs && !r_err)  r_sum <= w_sum_nx;
  end

  assign bus.out_bcd = r_bcd;
  assign bus.out_pos = r_pos;
  assign bus.out_err = r_err;
  assign sum_bcd     = r_sum;
endmodule

// File: tb/tb_jolt_finder_stream.sv
// Randomised bench for jolt_finder_stream against a greedy reference model.
// Two instances (NUM_PICK=2 and 12) share stimulus through a selector.
module tb_jolt_finder_stream;
  localparam int MAXL = 128;

  typedef logic [3:0] dq_t[$];
  typedef struct {
    logic [47:0] bcd;
    logic [6:0]  pos;
    logic        err;
    int          n;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sum_clr = 1'b0;
  logic sel = 1'b0;
  logic tb_valid = 1'b0, tb_last = 1'b0, tb_ready = 1'b0;
  logic [3:0] tb_digit = '0;
  bit hold = 1'b0, force_val = 1'b0;
  logic [63:0] sum2, sum12;

  always #5 clk = ~clk;

  jolt_finder_stream_if #(.MAX_LEN(MAXL), .NUM_PICK(2))  if2 ();
  jolt_finder_stream_if #(.MAX_LEN(MAXL), .NUM_PICK(12)) if12 ();

  assign if2.in_valid   = tb_valid && !sel;
  assign if2.in_digit   = tb_digit;
  assign if2.in_last    = tb_last;
  assign if2.out_ready  = tb_ready && !sel;
  assign if12.in_valid  = tb_valid && sel;
  assign if12.in_digit  = tb_digit;
  assign if12.in_last   = tb_last;
  assign if12.out_ready = tb_ready && sel;

  jolt_finder_stream #(.MAX_LEN(MAXL), .NUM_PICK(2), .ACC_DIGITS(16)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .sum_clr(sum_clr), .sum_bcd(sum2));
  jolt_finder_stream #(.MAX_LEN(MAXL), .NUM_PICK(12), .ACC_DIGITS(16)) dut12 (
    .clk(clk), .rst(rst), .bus(if12), .sum_clr(sum_clr), .sum_bcd(sum12));

  wire        w_in_ready  = sel ? if12.in_ready  : if2.in_ready;
  wire        w_out_valid = sel ? if12.out_valid : if2.out_valid;
  wire [47:0] w_bcd       = sel ? if12.out_bcd   : {40'b0, if2.out_bcd};
  wire [6:0]  w_pos       = sel ? if12.out_pos   : if2.out_pos;
  wire        w_err       = sel ? if12.out_err   : if2.out_err;
  wire [63:0] w_sum       = sel ? sum12 : sum2;

  int checks = 0, errors = 0, cyc = 0;
  longint m_sum = 0;
  exp_t expq[$];
  logic [47:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    tb_ready = hold ? force_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic longint bcd2int(input logic [63:0] b);
    longint r = 0;
    for (int i = 15; i >= 0; i--) r = r * 10 + longint'(b[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint v);
    logic [63:0] b = '0;
    for (int i = 0; i < 16; i++) begin
      b[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic dq_t s2q(input string s);
    dq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(4'(s[i] - 8'd48));
    return q;
  endfunction

  // Greedy selection: each pick is the leftmost maximum of its window
  function automatic void model(input dq_t d, input int p,
                                output logic [47:0] bcd, output logic [6:0] pos,
                                output logic err);
    int n, s, bi, best;
    bit bad;
    n = d.size();
    bad = 0;
    bcd = '0;
    pos = '0;
    foreach (d[i]) if (d[i] > 4'd9) bad = 1;
    err = bad || (n < p) || (n > MAXL);
    if (err) return;
    s = 0;
    for (int k = 0; k < p; k++) begin
      best = -1;
      bi = s;
      for (int i = s; i <= n - p + k; i++)
        if (int'(d[i]) > best) begin
          best = int'(d[i]);
          bi = i;
        end
      bcd = {bcd[43:0], 4'(best)};
      if (k == 0) pos = 7'(bi);
      s = bi + 1;
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int lat, p;
    bit prev_v;
    if (rst) begin
      prev_v = 0;
    end else begin
      p = sel ? 12 : 2;
      chk("sum", w_sum, int2bcd(m_sum));
      if (w_out_valid) begin
        chk("in_ready_low_in_out", {63'b0, w_in_ready}, 64'd0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got bcd %h with no bank pending", w_bcd);
        end else begin
          e = expq[0];
          chk("out_bcd", {16'b0, w_bcd}, {16'b0, e.bcd});
          chk("out_pos", {57'b0, w_pos}, {57'b0, e.pos});
          chk("out_err", {63'b0, w_err}, {63'b0, e.err});
          if (!prev_v && !e.err) begin
            lat = cyc - e.acc + 1;
            checks++;
            if (lat > (e.n - p + 1) * p + 1) begin
              errors++;
              $display("FAIL latency_bound: got %0d limit %0d", lat, (e.n - p + 1) * p + 1);
            end
            if (e.lat > 0) chk("latency_exact", 64'(lat), 64'(e.lat));
          end
          if (tb_ready) begin
            got.push_back(w_bcd);
            void'(expq.pop_front());
            if (!sum_clr && !e.err)
              m_sum = (m_sum + bcd2int({16'b0, e.bcd})) % 64'd10000000000000000;
          end
        end
      end
      if (sum_clr) m_sum = 0;
      prev_v = w_out_valid;
    end
  end

  task automatic send_bank(input dq_t d, input int lat_req);
    exp_t e;
    int t;
    logic acc;
    model(d, sel ? 12 : 2, e.bcd, e.pos, e.err);
    e.n = d.size();
    e.lat = lat_req;
    for (int i = 0; i < d.size(); i++) begin
      tb_valid = 1'b1;
      tb_digit = d[i];
      tb_last  = (i == d.size() - 1);
      t = 0;
      forever begin
        acc = w_in_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        t++;
        if (t > 5000) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: got 0 expected 1 within 5000 cycles");
          tb_valid = 1'b0;
          tb_last = 1'b0;
          return;
        end
      end
    end
    tb_valid = 1'b0;
    tb_last = 1'b0;
    e.acc = cyc;
    expq.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!w_out_valid && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!w_out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    sum_clr = 1'b1;
    @(posedge clk);
    #1;
    sum_clr = 1'b0;
  endtask

  function automatic dq_t rand_bank(input int lo, input int hi, input int bad_odds);
    dq_t q;
    int n = $urandom_range(lo, hi);
    for (int i = 0; i < n; i++)
      q.push_back(($urandom_range(0, bad_odds) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9)));
    return q;
  endfunction

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [47:0] mb;
    logic [6:0]  mp;
    logic        me;
    dq_t q;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready2",  {63'b0, if2.in_ready},  64'd1);
    chk("rst_out_valid2", {63'b0, if2.out_valid}, 64'd0);
    chk("rst_out_bcd2",   {56'b0, if2.out_bcd},   64'd0);
    chk("rst_out_pos2",   {57'b0, if2.out_pos},   64'd0);
    chk("rst_out_err2",   {63'b0, if2.out_err},   64'd0);
    chk("rst_sum2",       sum2,                   64'd0);
    chk("rst_in_ready12", {63'b0, if12.in_ready}, 64'd1);
    chk("rst_out_bcd12",  {16'b0, if12.out_bcd},  64'd0);
    chk("rst_sum12",      sum12,                  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    model(s2q("12984"), 2, mb, mp, me);
    chk("model_12984_bcd", {16'b0, mb}, 64'h98);
    chk("model_12984_pos", {57'b0, mp}, 64'd2);
    model(s2q("234234234278"), 12, mb, mp, me);
    chk("model_p12_bcd", {16'b0, mb}, 64'h234234234278);

    got.delete();
    send_bank(s2q("12984"), 0);
    drain();
    chk("t1_bcd", {16'b0, got[0]}, 64'h98);

    pulse_clr();
    got.delete();
    send_bank(s2q("987654321111111"), 0);
    send_bank(s2q("811111111111119"), 0);
    send_bank(s2q("234234234234278"), 0);
    send_bank(s2q("818181911112111"), 0);
    drain();
    chk("t2_r0", {16'b0, got[0]}, 64'h98);
    chk("t2_r1", {16'b0, got[1]}, 64'h89);
    chk("t2_r2", {16'b0, got[2]}, 64'h78);
    chk("t2_r3", {16'b0, got[3]}, 64'h92);
    chk("t2_sum", w_sum, 64'h357);

    send_bank(s2q("54321"), 9);
    drain();

    @(posedge clk);
    #1;
    hold = 1'b1;
    force_val = 1'b0;
    send_bank(s2q("31415"), 0);
    wait_valid();
    tb_valid = 1'b1;
    tb_digit = 4'd9;
    tb_last = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_still_valid", {63'b0, w_out_valid}, 64'd1);
    chk("t4_bcd_held", {16'b0, w_bcd}, 64'h45);
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    tb_last = 1'b0;
    hold = 1'b0;
    send_bank(s2q("2718"), 0);
    drain();

    send_bank(s2q("1A3"), 0);
    q.delete();
    for (int i = 0; i < MAXL + 3; i++) q.push_back(4'($urandom_range(0, 8)));
    send_bank(q, 0);
    send_bank(s2q("7"), 0);
    drain();

    for (int b = 0; b < 40; b++) send_bank(rand_bank(1, 24, 30), 0);
    drain();

    @(posedge clk);
    #1;
    hold = 1'b1;
    force_val = 1'b0;
    send_bank(s2q("55"), 0);
    wait_valid();
    sum_clr = 1'b1;
    force_val = 1'b1;
    @(posedge clk);
    #1;
    sum_clr = 1'b0;
    force_val = 1'b0;
    @(negedge clk);
    chk("clr_hs_sum", w_sum, 64'd0);
    chk("clr_hs_done", {63'b0, w_out_valid}, 64'd0);

    q.delete();
    for (int i = 0; i < 40; i++) q.push_back(4'd1);
    send_bank(q, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    m_sum = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_scan_in_ready",  {63'b0, w_in_ready},  64'd1);
    chk("rst_scan_out_valid", {63'b0, w_out_valid}, 64'd0);
    chk("rst_scan_bcd",       {16'b0, w_bcd},       64'd0);
    chk("rst_scan_pos",       {57'b0, w_pos},       64'd0);
    chk("rst_scan_err",       {63'b0, w_err},       64'd0);
    chk("rst_scan_sum",       w_sum,                64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 1'b0;

    @(posedge clk);
    #1;
    sel = 1'b1;
    got.delete();
    send_bank(s2q("987654321111111"), 0);
    send_bank(s2q("811111111111119"), 0);
    send_bank(s2q("234234234234278"), 0);
    send_bank(s2q("818181911112111"), 0);
    drain();
    chk("t3_r0", {16'b0, got[0]}, 64'h987654321111);
    chk("t3_r1", {16'b0, got[1]}, 64'h811111111119);
    chk("t3_r2", {16'b0, got[2]}, 64'h434234234278);
    chk("t3_r3", {16'b0, got[3]}, 64'h888911112111);
    chk("t3_sum", w_sum, 64'h3121910778619);

    send_bank(s2q("12345"), 0);
    drain();
    chk("t5_short_sum", w_sum, 64'h3121910778619);

    for (int b = 0; b < 25; b++) send_bank(rand_bank(1, 30, 40), 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
